// File: rtl/ahb_sif_mem.sv
// AHB-Lite slave memory model: configurable width/depth, per-stream wait states,
// two-cycle ERROR responses and a one-byte mailbox register.
module ahb_sif_mem #(
    parameter int          DW           = 64,
    parameter int          DEPTH        = 8192,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] MAILBOX_ADDR = 32'hD058_0000
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [2:0]    HBURST,
    input  logic [3:0]    HPROT,
    input  logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [DW-1:0] HRDATA,
    input  logic [3:0]    cfg_iws,
    input  logic [3:0]    cfg_dws,
    output logic          mbox_valid,
    output logic [7:0]    mbox_data
);
    localparam int          NB        = DW / 8;
    localparam int          LB        = $clog2(NB);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] SPAN      = 33'(DEPTH * NB);
    localparam int          MBOX_LANE = int'(MAILBOX_ADDR[LB-1:0]);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        hreadyout_q, hreadyout_d;
    logic        hresp_q, hresp_d;
    logic        mbox_valid_q, mbox_valid_d;
    logic [7:0]  mbox_data_q, mbox_data_d;

    logic [DW-1:0] mem [DEPTH];

    logic          accept, err, size_err, align_err, range_err;
    logic [31:0]   amask;
    logic [32:0]   off;
    logic [3:0]    ws;
    logic          mbox_hit, mem_we, rd_data;
    logic [AW-1:0] widx;
    logic [NB-1:0] be;
    int            lane;
    logic          unused_sigs;

    assign unused_sigs = ^{HBURST, HPROT[3:1], HTRANS[0]};

    // New address phases are only taken while the slave is showing HREADYOUT=1.
    assign accept = (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2)
                    && HSEL && HREADY && HTRANS[1];
    assign ws     = HPROT[0] ? cfg_dws : cfg_iws;

    assign amask     = (32'd1 << HSIZE) - 32'd1;
    assign off       = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign size_err  = {29'd0, HSIZE} > 32'(LB);
    assign align_err = |(HADDR & amask);
    assign range_err = (HADDR != MAILBOX_ADDR) && (off[32] || off >= SPAN);
    assign err       = size_err || align_err || range_err;

    assign mbox_hit = (addr_q == MAILBOX_ADDR);
    assign widx     = AW'((addr_q - BASE_ADDR) >> LB);
    assign mem_we   = (state_q == S_DATA) && write_q && !mbox_hit;
    assign rd_data  = (state_q == S_DATA) && !write_q && !mbox_hit;

    always_comb begin
        be   = '0;
        lane = int'(addr_q[LB-1:0]);
        for (int i = 0; i < NB; i++)
            be[i] = (i >= lane) && (i < lane + (1 << size_q));
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        write_d      = write_q;
        size_d       = size_q;
        cnt_d        = cnt_q;
        mbox_valid_d = 1'b0;
        mbox_data_d  = mbox_data_q;

        case (state_q)
            S_WAIT: begin
                if (cnt_q <= 4'd1) state_d = S_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_DATA && write_q && mbox_hit) begin
            mbox_valid_d = 1'b1;
            mbox_data_d  = HWDATA[MBOX_LANE*8 +: 8];
        end

        if (accept) begin
            addr_d  = HADDR;
            write_d = HWRITE;
            size_d  = HSIZE;
            if (err)             state_d = S_ERR1;
            else if (ws == 4'd0) state_d = S_DATA;
            else begin
                state_d = S_WAIT;
                cnt_d   = ws;
            end
        end

        hreadyout_d = !(state_d == S_WAIT || state_d == S_ERR1);
        hresp_d     = (state_d == S_ERR1 || state_d == S_ERR2);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            size_q       <= '0;
            cnt_q        <= '0;
            hreadyout_q  <= 1'b1;
            hresp_q      <= 1'b0;
            mbox_valid_q <= 1'b0;
            mbox_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            size_q       <= size_d;
            cnt_q        <= cnt_d;
            hreadyout_q  <= hreadyout_d;
            hresp_q      <= hresp_d;
            mbox_valid_q <= mbox_valid_d;
            mbox_data_q  <= mbox_data_d;
        end
    end

    // Array is not reset; commit uses the address latched before this edge.
    always_ff @(posedge HCLK) begin
        if (mem_we && HRESETn) begin
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[widx][i*8 +: 8] <= HWDATA[i*8 +: 8];
        end
    end

    assign HREADYOUT  = hreadyout_q;
    assign HRESP      = hresp_q;
    assign HRDATA     = rd_data ? mem[widx] : '0;
    assign mbox_valid = mbox_valid_q;
    assign mbox_data  = mbox_data_q;
endmodule
